// File: rtl/shift_left_sat_seq.sv
// ---------------------------------------------------------------------------
// shift_left_sat_seq
//
// Iterative arithmetic left shifter for signed Q12.9 neuron datapath values.
// Computes in_data * 2^shamt one bit per clock and saturates to the most
// positive / most negative code instead of wrapping. This is the up-scaling
// counterpart of the combinational arithmetic right shifter used for decay.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds valid and its payload
// stable until that edge, and the consumer may hold ready low for any number
// of cycles. in_ready is high only in IDLE, and out_valid is high only in
// DONE, so a new operand is never accepted in the cycle a result leaves.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream presents in_data / shamt
//   in_ready   out  block can accept an operand (IDLE)
//   in_data    in   WIDTH-bit signed operand
//   shamt      in   SHW-bit left-shift amount
//   out_valid  out  result available (DONE)
//   out_ready  in   downstream accepts result
//   out_data   out  WIDTH-bit signed shifted or saturated result
//   ovf        out  result was saturated; qualified by out_valid
//   dbg_state  out  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// ---------------------------------------------------------------------------
module shift_left_sat_seq #(
    parameter int WIDTH = 21,
    parameter int FRAC  = 9,   // fractional bits; documents the format only
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHW-1:0]   CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [SHW-1:0]   cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = in_data;
                    cnt_d   = shamt;
                    ovf_d   = 1'b0;
                    state_d = (shamt != '0) ? SHIFT : DONE;
                end
            end

            SHIFT: begin
                // If the two top bits differ, shifting once more would change
                // the sign, so clamp now. Checking before shifting means a
                // result that exactly fits is never flagged.
                if (acc_q[WIDTH-1] != acc_q[WIDTH-2]) begin
                    acc_d   = acc_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    acc_d = {acc_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_data  = acc_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_left_sat_seq.sv
module tb_shift_left_sat_seq;

    localparam int WIDTH = 21;
    localparam int SHW   = 4;
    localparam int MAX_WAIT = 40;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             ovf;
    logic [1:0]       dbg_state;

    int tests;
    int fails;

    shift_left_sat_seq #(.WIDTH(WIDTH), .FRAC(9), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present an operand one cycle, accept happens at edge E0.
    // Returns the number of edges after E0 until out_valid is seen (-1 on
    // timeout). All driving and sampling happens 1 time unit after posedge.
    task automatic run_op(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s,
                          output int lat);
        in_valid = 1'b1;
        in_data  = d;
        shamt    = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 2097151);
        shamt    = $urandom_range(0, 15);
        lat = 0;
        while (!out_valid && lat <= MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat > MAX_WAIT) lat = -1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        shamt = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
            ovf !== 1'b0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h ovf=%b state=%0d, expected 1 0 0 0 0",
                     in_ready, out_valid, out_data, ovf, dbg_state);
        end
    endtask

    task automatic test_shift_basic();
        int lat;
        run_op(21'h004C0, 4'd9, lat);
        tests++;
        if (lat !== 9 || out_data !== 21'h98000 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL shift_basic: lat=%0d data=%h ovf=%b, expected 9 098000 0", lat, out_data, ovf);
        end
        drain();
    endtask

    task automatic test_sat_pos();
        int lat;
        run_op(21'h004C0, 4'd10, lat);
        tests++;
        if (lat !== 10 || out_data !== 21'h0FFFFF || ovf !== 1'b1) begin
            fails++;
            $display("FAIL sat_pos: lat=%0d data=%h ovf=%b, expected 10 0fffff 1", lat, out_data, ovf);
        end
        drain();
    endtask

    task automatic test_sat_neg();
        int lat;
        run_op(21'h1FE200, 4'd9, lat);
        tests++;
        if (lat !== 8 || out_data !== 21'h100000 || ovf !== 1'b1) begin
            fails++;
            $display("FAIL sat_neg: lat=%0d data=%h ovf=%b, expected 8 100000 1", lat, out_data, ovf);
        end
        drain();
    endtask

    task automatic test_exact_fit();
        int lat;
        // Positive value landing in the top magnitude bit: fits, no flag.
        run_op(21'h040000, 4'd1, lat);
        tests++;
        if (lat !== 1 || out_data !== 21'h080000 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL fit_pos: lat=%0d data=%h ovf=%b, expected 1 080000 0", lat, out_data, ovf);
        end
        drain();
        // Negative value landing exactly on the most negative code.
        run_op(21'h180000, 4'd1, lat);
        tests++;
        if (lat !== 1 || out_data !== 21'h100000 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL fit_neg: lat=%0d data=%h ovf=%b, expected 1 100000 0", lat, out_data, ovf);
        end
        drain();
    endtask

    task automatic test_zero_operand();
        int lat;
        run_op(21'h000000, 4'd15, lat);
        tests++;
        if (lat !== 15 || out_data !== 21'h000000 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL zero_operand: lat=%0d data=%h ovf=%b, expected 15 000000 0", lat, out_data, ovf);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int lat;
        // Follows a saturating op, so ovf must also be cleared at accept.
        run_op(21'h1FFFFF, 4'd0, lat);
        tests++;
        if (lat !== 0 || out_data !== 21'h1FFFFF || ovf !== 1'b0) begin
            fails++;
            $display("FAIL zero_shift: lat=%0d data=%h ovf=%b, expected 0 1fffff 0", lat, out_data, ovf);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 21'h000123;
            shamt    = 4'd3;
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || out_data !== 21'h1FFFFF || ovf !== 1'b0 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold[%0d]: valid=%b data=%h ovf=%b in_ready=%b, expected 1 1fffff 0 0",
                         i, out_valid, out_data, ovf, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL no_same_cycle_accept: in_ready=%b, expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL release: in_ready=%b valid=%b state=%0d, expected 1 0 0", in_ready, out_valid, dbg_state);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        in_valid = 1'b1;
        in_data  = 21'h000003;
        shamt    = 4'd15;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (dbg_state !== 2'd1) begin
            fails++;
            $display("FAIL busy_before_abort: state=%0d, expected 1", dbg_state);
        end
        // Reset lands between step 3 and step 4.
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || ovf !== 1'b0 ||
            in_ready !== 1'b1 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL abort: valid=%b data=%h ovf=%b in_ready=%b state=%0d, expected 0 0 0 1 0",
                     out_valid, out_data, ovf, in_ready, dbg_state);
        end
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        tests++;
        if (seen !== 0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL post_abort_idle: valid_cycles=%0d state=%0d, expected 0 0", seen, dbg_state);
        end
        run_op(21'h000003, 4'd2, lat);
        tests++;
        if (lat !== 2 || out_data !== 21'h00000C || ovf !== 1'b0) begin
            fails++;
            $display("FAIL after_abort: lat=%0d data=%h ovf=%b, expected 2 00000c 0", lat, out_data, ovf);
        end
        drain();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_shift_basic();
        test_sat_pos();
        test_sat_neg();
        test_backpressure();
        test_exact_fit();
        test_zero_operand();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
